shift_seq: RTL

- Multi-cycle sequencer for the ALU shift path; replaces the single-cycle 5-stage barrel chain when timing or area requires it.
- Applies one power-of-two shift stage (16/8/4/2/1) per clock under an FSM.
- Uses a start/busy/done handshake to the multi-cycle ALU control.
- Supports the same operation encoding as the ALU shift unit: alufun 00 = SLL, 01 = SRL, 11 = SRA.

---
 rtl/shift_seq_if.sv | 13 +
 rtl/shift_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/shift_seq_if.sv
// shift_seq_if: start/busy/done handshake and operand bus for the multi-cycle shifter
interface shift_seq_if;
    logic        start;
    logic [1:0]  alufun;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        err;
    modport master(output start, alufun, a, b, input busy, done, res, err);
    modport slave(input start, alufun, a, b, output busy, done, res, err);
endinterface

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle SLL/SRL/SRA sequencer, one power-of-two stage per clock; SHIFT_SEQ_ROTATE_EN makes alufun 10 a rotate right
module shift_seq #(
    parameter int SKIP_ZERO = 1
) (
    input logic   clk,
    input logic   reset,
    shift_seq_if.slave s
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic ROT = 1'b1;
`else
    localparam logic ROT = 1'b0;
`endif
    state_t      state, state_n;
    logic [31:0] acc, acc_n, res_q, res_n;
    logic [4:0]  amt, amt_n;
    logic [1:0]  mode, mode_n;
    logic [2:0]  ptr, ptr_n, hi;
    logic        unused_b;

    function automatic logic bad(input logic [1:0] m);
        return !ROT && m == 2'b10;
    endfunction

    function automatic logic [31:0] stage(input logic [31:0] v, input logic [1:0] m, input logic [2:0] k);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 5; i++)
            if (k == 3'(i))
                r = m == 2'b00 ? v << (1 << i)
                  : m == 2'b01 ? v >> (1 << i)
                  : m == 2'b11 ? (v >> (1 << i)) | ({32{v[31]}} & ~(32'hFFFF_FFFF >> (1 << i)))
                  : (v >> (1 << i)) | (v << (32 - (1 << i)));
        return r;
    endfunction

    assign unused_b = ^s.b[31:5];
    assign s.busy   = state != IDLE;
    assign s.done   = state == DONE;
    assign s.err    = state == DONE && bad(mode);
    assign s.res    = res_q;

    // largest set bit of the remaining amount
    always_comb begin
        hi = '0;
        for (int i = 0; i < 5; i++)
            if (amt[i]) hi = 3'(i);
    end

    // next state and datapath updates
    always_comb begin
        state_n = state;
        acc_n   = acc;
        amt_n   = amt;
        mode_n  = mode;
        ptr_n   = ptr;
        case (state)
            IDLE: if (s.start) begin
                acc_n   = s.a;
                amt_n   = s.b[4:0];
                mode_n  = s.alufun;
                ptr_n   = 3'd4;
                state_n = (s.b[4:0] == 5'd0 || bad(s.alufun)) ? DONE : SHIFT;
            end
            SHIFT: if (SKIP_ZERO != 0) begin
                acc_n   = stage(acc, mode, hi);
                amt_n   = amt & ~(5'd1 << hi);
                state_n = amt_n == 5'd0 ? DONE : SHIFT;
            end else begin
                acc_n   = amt[ptr] ? stage(acc, mode, ptr) : acc;
                ptr_n   = ptr - 3'd1;
                state_n = ptr == 3'd0 ? DONE : SHIFT;
            end
            default: state_n = IDLE;
        endcase
        res_n = state_n == DONE ? acc_n : res_q;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // accumulator, amount, mode, stage pointer and result registers
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            acc   <= '0;
            amt   <= '0;
            mode  <= '0;
            ptr   <= '0;
            res_q <= '0;
        end else begin
            acc   <= acc_n;
            amt   <= amt_n;
            mode  <= mode_n;
            ptr   <= ptr_n;
            res_q <= res_n;
        end
endmodule
